// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the boot-loaded instruction memory: bus widths, NOP
// encoding, loader state encodings and the byte-lane insert helper.
package inst_mem_loader_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERR     = 3'd4
  } ld_state_e;

  // Little-endian assembly: byte k of a word lands in lane [8k+7:8k].
  function automatic logic [INST_W-1:0] put_byte(input logic [INST_W-1:0] word,
                                                 input logic [1:0]        lane,
                                                 input logic [7:0]        data);
    logic [INST_W-1:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = data;
      2'd1:    w[15:8]  = data;
      2'd2:    w[23:16] = data;
      default: w[31:24] = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream load channel plus the core's fetch bus; the loader is the slave,
// the upstream source and the fetching core are the master.
interface inst_mem_loader_if;
  import inst_mem_loader_pkg::*;

  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              rom_ce_i;
  logic [ADDR_W-1:0] rom_addr_i;
  logic [INST_W-1:0] rom_data_o;

  modport master (
    output byte_valid_i, byte_data_i, rom_ce_i, rom_addr_i,
    input  byte_ready_o, rom_data_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i, rom_ce_i, rom_addr_i,
    output byte_ready_o, rom_data_o
  );

endinterface

// File: rtl/inst_mem_loader_array.sv
// Instruction storage: synchronous write port, asynchronous read port.
// Contents are deliberately never reset.
module inst_mem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [31:0]                    wdata_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write one assembled word per enabled edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-loader FSM in front of the instruction memory. Optional trailing
// checksum word is enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LEN_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_start_i,
  input  logic [LEN_W-1:0]     load_len_i,
  inst_mem_loader_if.slave     bus,
  output logic                 core_rst_n_o,
  output logic                 load_busy_o,
  output logic                 load_done_o,
  output logic                 load_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  ld_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       word_s;
  logic              we_s;
  logic              accept_s;
  logic              start_bad_s;
  logic              core_rst_n_q, ready_q, busy_q, done_q, err_q;
  logic [31:0]       rdata_s;
  logic [31:0]       rom_data_s;
  logic              unused_addr_s;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  assign start_bad_s = (load_len_i == {LEN_W{1'b0}}) || (load_len_i > LEN_W'(DEPTH_WORDS));
  assign accept_s    = (state_q == ST_LOAD) && bus.byte_valid_i && ready_q;
  assign word_s      = put_byte(asm_q, cnt_q, bus.byte_data_i);

  // Next-state, byte assembly and memory write strobe.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    we_s    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (load_start_i) begin
          if (start_bad_s) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_LOAD;
            len_d   = load_len_i;
            ptr_d   = {LEN_W{1'b0}};
            cnt_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = 32'h0;
`endif
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          cnt_d = cnt_q + 2'd1;
          asm_d = word_s;
          if (cnt_q == 2'd3) begin
            if (ptr_q < len_q) begin
              we_s  = 1'b1;
              ptr_d = ptr_q + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
              csum_d = csum_q + word_s;
            end else if (word_s == csum_q) begin
              state_d = ST_RELEASE;
            end else begin
              state_d = ST_ERR;
            end
`else
              if (ptr_q == len_q - LEN_W'(1)) begin
                state_d = ST_RELEASE;
              end else begin
                state_d = ST_LOAD;
              end
            end else begin
              state_d = ST_ERR;
            end
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; the core reset only lifts once RUN persists.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      len_q        <= {LEN_W{1'b0}};
      ptr_q        <= {LEN_W{1'b0}};
      cnt_q        <= 2'd0;
      asm_q        <= 32'h0;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      core_rst_n_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
      ready_q      <= (state_d == ST_LOAD);
      busy_q       <= (state_d == ST_LOAD) || (state_d == ST_RELEASE);
      done_q       <= (state_d == ST_RUN);
      err_q        <= (state_d == ST_ERR);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of written data words.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      csum_q <= 32'h0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  inst_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i   (clk_i),
    .we_i    (we_s),
    .waddr_i (ptr_q[AW-1:0]),
    .wdata_i (word_s),
    .raddr_i (bus.rom_addr_i[AW+1:2]),
    .rdata_o (rdata_s)
  );

  // Fetch mux: silent outside RUN, NOP beyond the array.
  always_comb begin
    rom_data_s = 32'h0;
    if (!bus.rom_ce_i || (state_q != ST_RUN)) begin
      rom_data_s = 32'h0;
    end else if (bus.rom_addr_i[ADDR_W-1:AW+2] != {(ADDR_W-AW-2){1'b0}}) begin
      rom_data_s = NOP_INSN;
    end else begin
      rom_data_s = rdata_s;
    end
  end

  assign unused_addr_s    = ^bus.rom_addr_i[1:0];
  assign bus.rom_data_o   = rom_data_s;
  assign bus.byte_ready_o = ready_q;
  assign core_rst_n_o     = core_rst_n_q;
  assign load_busy_o      = busy_q;
  assign load_done_o      = done_q;
  assign load_err_o       = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader; checksum cases run when
// LOADER_CHECKSUM_EN is defined.
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LW    = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          load_start_i;
  logic [LW-1:0] load_len_i;
  logic          core_rst_n_o, load_busy_o, load_done_o, load_err_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prog_q[$];

  always #5 clk_i = ~clk_i;

  inst_mem_loader_if bus();

  inst_mem_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .bus          (bus),
    .core_rst_n_o (core_rst_n_o),
    .load_busy_o  (load_busy_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_load(input logic [LW-1:0] len);
    @(negedge clk_i);
    load_start_i = 1'b1;
    load_len_i   = len;
    @(negedge clk_i);
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clk_i);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    for (int t = 0; t < 50; t++) begin
      if (bus.byte_ready_o) break;
      @(negedge clk_i);
    end
    if (!bus.byte_ready_o) check("byte_accept_timeout", {31'h0, bus.byte_ready_o}, 32'h1);
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  task automatic send_program(input int max_gap);
    logic [31:0] sum;
    sum = 32'h0;
    foreach (prog_q[i]) begin
      send_word(prog_q[i], max_gap);
      exp_q.push_back(prog_q[i]);
      sum = sum + prog_q[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(sum, max_gap);
`endif
  endtask

  // Counts edges after the last accepted byte until the core reset lifts.
  task automatic check_release(input string tag);
    int n;
    n = 0;
    while (!core_rst_n_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, n, 32'd2);
  endtask

  task automatic read_check(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      bus.rom_ce_i   = 1'b1;
      bus.rom_addr_i = 32'(i * 4);
      #1;
      check(tag, bus.rom_data_o, exp_q.pop_front());
    end
  endtask

  task automatic read_at(input string tag, input logic ce, input logic [31:0] addr,
                         input logic [31:0] exp);
    @(negedge clk_i);
    bus.rom_ce_i   = ce;
    bus.rom_addr_i = addr;
    #1;
    check(tag, bus.rom_data_o, exp);
  endtask

  initial begin
    rst_i            = 1'b0;
    load_start_i     = 1'b0;
    load_len_i       = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    bus.rom_ce_i     = 1'b1;
    bus.rom_addr_i   = 32'h0;

    repeat (3) @(negedge clk_i);
    #1;
    check("rst_core", {31'h0, core_rst_n_o}, 32'h0);
    check("rst_rom", bus.rom_data_o, 32'h0);
    check("rst_ready", {31'h0, bus.byte_ready_o}, 32'h0);
    check("rst_busy", {31'h0, load_busy_o}, 32'h0);
    check("rst_done", {31'h0, load_done_o}, 32'h0);
    check("rst_err", {31'h0, load_err_o}, 32'h0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_core", {31'h0, core_rst_n_o}, 32'h0);
    check("idle_busy", {31'h0, load_busy_o}, 32'h0);

    // Basic back-to-back load.
    prog_q = '{32'h0000_0013, 32'h0010_0093};
    start_load(16'd2);
    check("load_busy", {31'h0, load_busy_o}, 32'h1);
    send_program(0);
    check_release("basic_release");
    check("basic_done", {31'h0, load_done_o}, 32'h1);
    read_check("basic_read");
    read_at("rd_addr4", 1'b1, 32'h4, 32'h0010_0093);
    read_at("rd_addr6", 1'b1, 32'h6, 32'h0010_0093);
    read_at("rd_oob", 1'b1, 32'h1000, 32'h0000_0013);
    read_at("rd_oob_top", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013);
    read_at("rd_ce0", 1'b0, 32'h4, 32'h0);

    // Bytes offered in RUN are never taken.
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'hFF;
    repeat (3) begin
      @(negedge clk_i);
      check("run_no_ready", {31'h0, bus.byte_ready_o}, 32'h0);
    end
    bus.byte_valid_i = 1'b0;
    read_at("run_mem_kept", 1'b1, 32'h0, 32'h0000_0013);

    // Reload from RUN with stalls.
    start_load(16'd2);
    check("reload_core_drop", {31'h0, core_rst_n_o}, 32'h0);
    send_program(3);
    check_release("stall_release");
    read_check("stall_read");

    // Invalid lengths.
    start_load(16'd0);
    check("len0_err", {31'h0, load_err_o}, 32'h1);
    check("len0_core", {31'h0, core_rst_n_o}, 32'h0);
    start_load(16'd1025);
    check("len1025_err", {31'h0, load_err_o}, 32'h1);
    check("len1025_core", {31'h0, core_rst_n_o}, 32'h0);
    read_at("err_rom", 1'b1, 32'h0, 32'h0);

    // Recovery with fresh random program.
    prog_q = '{$urandom(), $urandom(), $urandom()};
    start_load(16'd3);
    check("recover_err_clr", {31'h0, load_err_o}, 32'h0);
    send_program(2);
    check_release("recover_release");
    read_check("recover_read");

`ifdef LOADER_CHECKSUM_EN
    start_load(16'd2);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0010_00A6, 0);
    check_release("cs_ok_release");
    check("cs_ok_done", {31'h0, load_done_o}, 32'h1);
    start_load(16'd2);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'h0010_00A7, 0);
    check("cs_bad_err", {31'h0, load_err_o}, 32'h1);
    check("cs_bad_core", {31'h0, core_rst_n_o}, 32'h0);
`endif

    // Reset in the middle of a load.
    start_load(16'd2);
    send_byte(8'hAA, 0);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_busy", {31'h0, load_busy_o}, 32'h0);
    check("midrst_ready", {31'h0, bus.byte_ready_o}, 32'h0);
    check("midrst_core", {31'h0, core_rst_n_o}, 32'h0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Instruction memory with a boot-loader FSM, directly upstream of the core's fetch port.
- Before execution, receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words into the memory array.
- Holds the core in reset while loading, then releases it and serves combinational instruction reads from the core's rom_addr_o / rom_ce_o.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit instruction words; must be a power of two.
- LEN_W, 16, width of the word-count input.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous active-low reset.
- load_start_i  in  1  one-cycle pulse that starts a program load.
- load_len_i  in  LEN_W  number of program words; sampled on load_start_i.
- byte_valid_i  in  1  upstream byte available.
- byte_data_i  in  8  program byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- rom_ce_i  in  1  fetch enable from the core.
- rom_addr_i  in  32  byte address from the core.
- rom_data_o  out  32  instruction word to the core's rom_data_i.
- core_rst_n_o  out  1  active-low reset for the core (0 = core held).
- load_busy_o  out  1  high in the LOAD and RELEASE states.
- load_done_o  out  1  high in the RUN state.
- load_err_o  out  1  high in the ERR state.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; word_ptr=0; byte_cnt=0.
  - core_rst_n_o=0, byte_ready_o=0, load_busy_o=0, load_done_o=0, load_err_o=0, rom_data_o=0.
  - Memory contents are not cleared.
- States are IDLE, LOAD, RELEASE, RUN, ERR.
- IDLE: core held in reset.
  - On load_start_i: if load_len_i==0 or load_len_i>DEPTH_WORDS, go to ERR.
  - Otherwise latch the length, clear word_ptr and byte_cnt, and go to LOAD.
- LOAD: byte_ready_o=1.
  - A byte is accepted on the rising edge where byte_valid_i && byte_ready_o.
  - Byte k (k = byte_cnt, 0..3) goes to lane [8k+7:8k].
  - On the 4th byte, the assembled word is written to mem[word_ptr] on that same edge, word_ptr increments, and byte_cnt wraps to 0.
  - When the last word is written, go to RELEASE.
  - load_start_i is ignored in LOAD.
- RELEASE: exactly one cycle, byte_ready_o=0, core still held; then go to RUN.
  - core_rst_n_o rises 2 cycles after the edge that writes the last word.
- RUN: core_rst_n_o=1, load_done_o=1, byte_ready_o=0.
  - load_start_i re-enters the same check as IDLE.
  - core_rst_n_o drops on the next edge, whether the next state is LOAD or ERR.
- ERR: core_rst_n_o=0, load_err_o=1; leaves only on load_start_i (same check as IDLE).
- Reads are combinational, using index = rom_addr_i[log2(DEPTH_WORDS)+1:2]; bits [1:0] are ignored.
  - rom_data_o = 0 when rom_ce_i=0 or state≠RUN.
  - rom_data_o = 32'h00000013 (NOP) when rom_addr_i ≥ 4*DEPTH_WORDS.
  - Otherwise rom_data_o = mem[index].
- Extra bytes arriving outside LOAD are never accepted, because byte_ready_o=0.
- Reset asserted mid-load: the loader returns to IDLE immediately; partially written words remain in the array.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, LOAD accepts one additional 4-byte checksum word, which is not written to memory.
  - Checksum = mod-2^32 sum of all data words, accumulated as each word is written and cleared on load start.
  - Match → RELEASE; mismatch → ERR.
- Undefined: no checksum word; the accumulator logic is absent.

Decomposition:
- Shared define file holds:
  - NOP encoding 32'h00000013.
  - State encodings: IDLE, LOAD, RELEASE, RUN, ERR.
  - Instruction bus and address bus widths, reusing the existing core bus definitions.
- Sub-module inst_mem_array: DEPTH_WORDS x 32, synchronous write port, asynchronous read port.
- The FSM, byte assembly and checksum logic stay in inst_mem_loader.

Test Plan:
- Reset: hold rst_i=0 → core_rst_n_o=0, rom_data_o=0, byte_ready_o=0, all status outputs 0. Release → still IDLE, core held.
- Basic load: load_len_i=2, bytes 13 00 00 00 93 00 10 00 streamed back-to-back → mem[0]=32'h00000013, mem[1]=32'h00100093; core_rst_n_o=1 two cycles after the 8th byte; rom_ce_i=1 with addr 4 → 32'h00100093.
- Handshake stalls: same stream with random 0–3-cycle byte_valid_i gaps → identical memory contents and identical release timing relative to the last byte.
- Invalid lengths: load_len_i=0, then load_len_i=1025 → load_err_o=1 and core_rst_n_o=0 in both cases. A valid load_start_i afterwards recovers and completes normally.
- Read boundaries in RUN: addr 32'h1000 with DEPTH 1024 → 32'h00000013; rom_ce_i=0 → 0; addr 6 → mem[1].
- Checksum (LOADER_CHECKSUM_EN defined): after the basic load stream, send checksum 32'h001000A6 → RUN; send checksum 32'h001000A7 → ERR with load_err_o=1.
